md_sched: RTL and testbench

- Multiply/divide scheduler for the pipelined MIPS core; sits in E stage beside the ALU.
- Accepts mult/div requests from the E-stage instruction and runs them over a fixed multi-cycle latency.
- Owns the HI/LO registers and services mthi/mtlo writes.
- Generates the D-stage stall when an HI/LO-using instruction meets an in-flight or just-issued operation; stall is ORed into the existing hazard stall by the top level.

---
 rtl/md_sched.sv | 177 +++++++++++++++++
 tb/tb_md_sched.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/md_sched.sv
// md_sched -- multiply/divide scheduler for the E stage of the pipelined MIPS core.
//
// The block computes a mult/div result as soon as the request arrives and keeps it
// in a pending register. It then holds the unit busy for a fixed latency. When the
// latency expires, the result is committed into the architectural HI/LO registers.
// The block also services mthi/mtlo writes and raises the D-stage stall request.
//
// Optional feature: define MD_MADD_EN to enable madd/maddu/msub/msubu (md_op 4..7).
// These ops accumulate into {hi,lo}. When the macro is undefined, codes 4..7 never
// start an operation.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-low
//   start     E-stage instruction is mult/div class
//   md_op     0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu, 6 msub, 7 msubu
//   a, b      forwarded rs / rt operands
//   wr_hi     mthi in E stage
//   wr_lo     mtlo in E stage
//   wr_data   mthi/mtlo data
//   md_use_d  D-stage instruction touches the mult/div unit or HI/LO
//   busy      operation in flight
//   stall     D-stage stall request (ORed into the hazard stall by the top level)
//   hi, lo    architectural HI/LO registers
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wr_data,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int MAX_C = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    p_hi_q, p_hi_d;
  logic [31:0]    p_lo_q, p_lo_d;
  logic [31:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;

  logic           op_legal;
  logic           start_ok;
  logic           is_div;
  logic [CW-1:0]  n_load;
  logic [63:0]    res;

  // Products. Both operands are extended to 64 bits, so the low 64 bits of the
  // product are exact for signed and for unsigned operands.
  logic [63:0]    prod_s, prod_u;
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed division runs on magnitudes, and the signs are fixed up afterwards.
  // The quotient truncates toward zero. The remainder takes the sign of the dividend.
  // 0x80000000 / -1 produces a magnitude of 0x80000000. Negating that value leaves it
  // unchanged, which gives lo = 0x80000000 and hi = 0 as required.
  // A zero divisor is replaced by 1 so the datapath stays defined. The result is
  // discarded in that case.
  logic           b_nz;
  logic [31:0]    abs_a, abs_b, den_s, den_u;
  logic [31:0]    uq_s, ur_s, q_s, r_s, q_u, r_u;
  assign b_nz  = (b != 32'd0);
  assign abs_a = a[31] ? (32'd0 - a) : a;
  assign abs_b = b[31] ? (32'd0 - b) : b;
  assign den_s = b_nz ? abs_b : 32'd1;
  assign den_u = b_nz ? b : 32'd1;
  assign uq_s  = abs_a / den_s;
  assign ur_s  = abs_a % den_s;
  assign q_s   = (a[31] ^ b[31]) ? (32'd0 - uq_s) : uq_s;
  assign r_s   = a[31] ? (32'd0 - ur_s) : ur_s;
  assign q_u   = a / den_u;
  assign r_u   = a % den_u;

`ifdef MD_MADD_EN
  assign op_legal = 1'b1;
`else
  assign op_legal = ~md_op[2];
`endif

  assign start_ok = start & op_legal & (state_q == IDLE);
  assign is_div   = (md_op == 3'd2) || (md_op == 3'd3);
  assign n_load   = is_div ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);

  // Result latched at issue. A divide by zero re-latches the current HI/LO value,
  // so the commit at the end of the operation leaves HI/LO unchanged.
  always_comb begin
    res = {hi_q, lo_q};
    case (md_op)
      3'd0: res = prod_s;
      3'd1: res = prod_u;
      3'd2: res = b_nz ? {r_s, q_s} : {hi_q, lo_q};
      3'd3: res = b_nz ? {r_u, q_u} : {hi_q, lo_q};
`ifdef MD_MADD_EN
      3'd4: res = {hi_q, lo_q} + prod_s;
      3'd5: res = {hi_q, lo_q} + prod_u;
      3'd6: res = {hi_q, lo_q} - prod_s;
      3'd7: res = {hi_q, lo_q} - prod_u;
`endif
      default: res = {hi_q, lo_q};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          // A start in the same cycle as mthi/mtlo takes priority, and the write is dropped.
          {p_hi_d, p_lo_d} = res;
          cnt_d            = n_load;
          state_d          = RUN;
        end else begin
          if (wr_hi) hi_d = wr_data;
          if (wr_lo) lo_d = wr_data;
        end
      end
      RUN: begin
        // start and wr_* are ignored while busy. The pipeline stall prevents them anyway.
        if (cnt_q == '0) begin
          hi_d    = p_hi_q;
          lo_d    = p_lo_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == RUN);
  // The raw start is used here, so an illegal op still stalls for one cycle.
  // That is harmless and keeps this path short.
  assign stall = md_use_d & (start | busy);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed testbench for md_sched. Expected HI/LO results are pushed to a queue when
// an operation is issued. They are popped and compared once busy falls.
module tb_md_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        wr_hi, wr_lo;
  logic [31:0] wr_data;
  logic        md_use_d;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mhl;  // bench's own model of {hi,lo}

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .md_op(md_op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data), .md_use_d(md_use_d),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] cur);
    longint sx, sy, q, r;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (op)
      3'd0: model = sx * sy;
      3'd1: model = ux * uy;
      3'd2: begin
        if (y == 0) model = cur;
        else begin
          q = sx / sy;
          r = sx % sy;
          model = {r[31:0], q[31:0]};
        end
      end
      3'd3: model = (y == 0) ? cur : {32'(ux % uy), 32'(ux / uy)};
      default: model = cur;
    endcase
  endfunction

  // Issue one op, count busy cycles, then compare the committed HI/LO against the
  // scoreboard. When poke is set, a start and mthi/mtlo are driven mid-operation.
  task automatic run_op(input logic [2:0] op, input logic [31:0] oa, input logic [31:0] ob,
                        input logic [63:0] expv, input int n, input bit chk_stall,
                        input bit poke, input string tag);
    int cnt;
    logic [63:0] want;
    @(negedge clk);
    start = 1'b1; md_op = op; a = oa; b = ob; md_use_d = chk_stall;
    exp_q.push_back(expv);
    if (chk_stall) begin
      #1;
      check({tag, "_stall_start"}, {63'd0, stall}, 64'd1);
    end
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy && cnt < 200) begin
      cnt++;
      if (chk_stall) check({tag, "_stall_busy"}, {63'd0, stall}, 64'd1);
      if (poke && cnt == 2) begin
        start = 1'b1; md_op = 3'd0; wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 32'hDEADBEEF;
      end else begin
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(cnt), 64'(n));
    if (chk_stall) check({tag, "_stall_after"}, {63'd0, stall}, 64'd0);
    md_use_d = 1'b0;
    want = exp_q.pop_front();
    check({tag, "_hilo"}, {hi, lo}, want);
    $display("[TB] op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d", op, oa, ob, hi, lo, cnt);
    mhl = expv;
  endtask

  task automatic mt(input bit h, input bit l, input logic [31:0] d, input string tag);
    @(negedge clk);
    wr_hi = h; wr_lo = l; wr_data = d; md_use_d = 1'b1;
    #1;
    check({tag, "_stall"}, {63'd0, stall}, 64'd0);
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0; md_use_d = 1'b0;
    if (h) mhl[63:32] = d;
    if (l) mhl[31:0] = d;
    check({tag, "_hilo"}, {hi, lo}, mhl);
    $display("[TB] mthi=%0b mtlo=%0b data=%h -> hi=%h lo=%h", h, l, d, hi, lo);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] e;
    rst = 1'b0; start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0;
    wr_hi = 1'b0; wr_lo = 1'b0; wr_data = 32'd0; md_use_d = 1'b0;
    mhl = 64'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_stall", {63'd0, stall}, 64'd0);
    $display("[TB] reset -> hi=%h lo=%h busy=%0b stall=%0b", hi, lo, busy, stall);

    run_op(3'd0, 32'hFFFFFFFF, 32'd2, 64'hFFFFFFFF_FFFFFFFE, 5, 1'b0, 1'b0, "mult");
    run_op(3'd1, 32'hFFFFFFFF, 32'd2, 64'h00000001_FFFFFFFE, 5, 1'b0, 1'b0, "multu");
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 10, 1'b1, 1'b0, "div");
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 10, 1'b0, 1'b0, "div_ovf");

    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 3) ? 32'($urandom_range(1, 9)) : $urandom;
      e   = model(rop, ra, rb, mhl);
      run_op(rop, ra, rb, e, (rop >= 3'd2) ? 10 : 5, 1'b0, 1'b0, "rand");
    end

    mt(1'b0, 1'b1, 32'h12345678, "mtlo");
    // divu by zero with mthi/mtlo and a second start poked mid-flight: all ignored
    run_op(3'd3, 32'd100, 32'd0, mhl, 10, 1'b1, 1'b1, "divu0");
    mt(1'b1, 1'b1, 32'hA5A5A5A5, "mt_both");

    // reset on the 3rd busy cycle of a mult aborts it
    @(negedge clk);
    start = 1'b1; md_op = 3'd0; a = 32'd3; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_pre", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mhl = 64'd0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    repeat (6) @(negedge clk);
    check("abort_no_commit", {hi, lo}, 64'd0);
    $display("[TB] abort mult -> busy=%0b hi=%h lo=%h", busy, hi, lo);

    mt(1'b1, 1'b0, 32'h00000000, "mthi0");
    mt(1'b0, 1'b1, 32'h00000001, "mtlo1");
`ifdef MD_MADD_EN
    run_op(3'd6, 32'd1, 32'd2, 64'hFFFFFFFF_FFFFFFFF, 5, 1'b0, 1'b0, "msub");
`else
    @(negedge clk);
    start = 1'b1; md_op = 3'd6; a = 32'd1; b = 32'd2; md_use_d = 1'b1;
    #1;
    check("msub_off_stall", {63'd0, stall}, 64'd1);
    @(negedge clk);
    start = 1'b0; md_use_d = 1'b0;
    check("msub_off_busy", {63'd0, busy}, 64'd0);
    repeat (5) @(negedge clk);
    check("msub_off_busy_late", {63'd0, busy}, 64'd0);
    check("msub_off_hilo", {hi, lo}, mhl);
    $display("[TB] msub (disabled) -> busy=%0b hi=%h lo=%h", busy, hi, lo);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
